dmem_mmio_bridge: RTL



---
 rtl/dmem_mmio_bridge_if.sv | 26 ++
 rtl/dmem_mmio_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_bridge_if.sv
// Data-memory bus between the core's M1/M2 stages and dmem_mmio_bridge.
//   MemWrite_EN : per-byte write enables (bit i covers WriteData[8i+7:8i])
//   MemAddr     : byte address presented in M1
//   WriteData   : lane-aligned store data presented in M1
//   ReadData    : registered read data, valid one cycle after the address
// The core takes the master modport and the bridge takes the slave modport.
interface dmem_mmio_bridge_if;
  logic [3:0]  MemWrite_EN;
  logic [31:0] MemAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite_EN,
    output MemAddr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite_EN,
    input  MemAddr,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data-side memory system for the pipelined core. It decodes the dmem bus
// into a byte-writable data RAM (region 0x0) and an MMIO block (region 0x1)
// holding an LED register, a FIFO-buffered 8N1 UART transmitter and a
// 64-bit free-running cycle timer. Reads are side-effect free, read-first
// and return exactly one cycle after the address.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high reset
//   bus     : dmem bus (slave side): MemWrite_EN, MemAddr, WriteData, ReadData
//   uart_tx : UART serial line, idle high
//   led     : LED register contents
module dmem_mmio_bridge #(
  parameter int RAM_WORDS    = 4096,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int LED_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_mmio_bridge_if.slave    bus,
  output logic                 uart_tx,
  output logic [LED_WIDTH-1:0] led
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  // MMIO word offsets (MemAddr[7:2])
  localparam logic [5:0] OFF_LED      = 6'h00;
  localparam logic [5:0] OFF_TX_DATA  = 6'h01;
  localparam logic [5:0] OFF_STATUS   = 6'h02;
  localparam logic [5:0] OFF_MTIME_LO = 6'h04;
  localparam logic [5:0] OFF_MTIME_HI = 6'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // ---------------- address decode ----------------
  logic          sel_ram_s;
  logic          sel_mmio_s;
  logic [5:0]    mmio_off_s;
  logic [AW-1:0] ram_idx_s;
  logic          push_req_s;
  logic          clr_ovf_s;
  logic          led_wr_s;
  logic          unused_s;

  assign sel_ram_s  = (bus.MemAddr[31:28] == 4'h0);
  assign sel_mmio_s = (bus.MemAddr[31:28] == 4'h1);
  assign mmio_off_s = bus.MemAddr[7:2];
  assign ram_idx_s  = bus.MemAddr[AW+1:2];
  assign push_req_s = sel_mmio_s && (mmio_off_s == OFF_TX_DATA) && bus.MemWrite_EN[0];
  assign clr_ovf_s  = sel_mmio_s && (mmio_off_s == OFF_STATUS) && bus.MemWrite_EN[0]
                      && bus.WriteData[3];
  assign led_wr_s   = sel_mmio_s && (mmio_off_s == OFF_LED);
  // Byte-offset bits and aliased upper bits carry no meaning here.
  assign unused_s   = ^{bus.MemAddr[27:8], bus.MemAddr[1:0]};

  // ---------------- storage ----------------
  logic [31:0]          mem_r [RAM_WORDS];
  logic [7:0]           fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 overflow_r;
  logic [LED_WIDTH-1:0] led_r;
  logic [63:0]          mtime_r;
  logic [31:0]          rd_data_r;

  logic fifo_full_s;
  logic fifo_empty_s;
  logic push_ok_s;
  logic pop_s;
  logic busy_s;
  logic [7:0] fifo_head_s;

  assign fifo_full_s  = (count_r == CNT_FULL);
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  // A push into a full FIFO is dropped even when a pop happens the same cycle.
  assign push_ok_s    = push_req_s && !fifo_full_s;
  assign fifo_head_s  = fifo_mem_r[rd_ptr_r];

  // ---------------- TX FSM registers ----------------
  tx_state_e     state_r;
  tx_state_e     state_nxt_s;
  logic [BW-1:0] baud_cnt_r;
  logic [BW-1:0] baud_nxt_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_nxt_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nxt_s;
  logic          uart_tx_r;
  logic          tx_nxt_s;
  logic          baud_last_s;

  assign baud_last_s = (baud_cnt_r == BAUD_LAST);

  // RAM byte-lane writes; contents survive reset, writes are blocked during it
  always_ff @(posedge clk) begin
    if (!reset && sel_ram_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.MemWrite_EN[i]) begin
          mem_r[ram_idx_s][8*i +: 8] <= bus.WriteData[8*i +: 8];
        end
      end
    end
  end

  // TX FIFO byte storage
  always_ff @(posedge clk) begin
    if (!reset && push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.WriteData[7:0];
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_req_s && fifo_full_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // LED register with per-lane writes
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r <= {LED_WIDTH{1'b0}};
    end else if (led_wr_s) begin
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (bus.MemWrite_EN[i/8]) begin
          led_r[i] <= bus.WriteData[i];
        end
      end
    end
  end

  // Free-running 64-bit cycle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_r <= 64'h0;
    end else begin
      mtime_r <= mtime_r + 64'h1;
    end
  end

  // TX FSM state register; uart_tx is registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {BW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      uart_tx_r  <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      bit_idx_r  <= bit_nxt_s;
      shift_r    <= shift_nxt_s;
      uart_tx_r  <= tx_nxt_s;
    end
  end

  // TX FSM next state; the line level is computed for the state being entered
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_cnt_r;
    bit_nxt_s   = bit_idx_r;
    shift_nxt_s = shift_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_START;
          baud_nxt_s  = {BW{1'b0}};
          shift_nxt_s = fifo_head_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          state_nxt_s = ST_DATA;
          baud_nxt_s  = {BW{1'b0}};
          bit_nxt_s   = 3'd0;
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_nxt_s  = {BW{1'b0}};
          shift_nxt_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            bit_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_nxt_s = {BW{1'b0}};
          // Back-to-back frames: next start bit follows the stop bit directly.
          if (pop_s) begin
            state_nxt_s = ST_START;
            shift_nxt_s = fifo_head_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = {BW{1'b0}};
      end
    endcase
    case (state_nxt_s)
      ST_START: tx_nxt_s = 1'b0;
      ST_DATA:  tx_nxt_s = shift_nxt_s[0];
      default:  tx_nxt_s = 1'b1;
    endcase
  end

  // TX FSM outputs: FIFO pop request and busy flag
  always_comb begin
    pop_s  = 1'b0;
    busy_s = (state_r != ST_IDLE);
    if (!fifo_empty_s) begin
      case (state_r)
        ST_IDLE: pop_s = 1'b1;
        ST_STOP: pop_s = baud_last_s;
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Read mux over pre-write state, giving read-first behaviour
  logic [31:0] rd_data_s;
  logic [31:0] status_s;
  logic [31:0] led_rd_s;

  always_comb begin
    led_rd_s = 32'h0;
    for (int i = 0; i < LED_WIDTH; i++) begin
      led_rd_s[i] = led_r[i];
    end
    status_s            = 32'h0;
    status_s[0]         = fifo_full_s;
    status_s[1]         = fifo_empty_s;
    status_s[2]         = busy_s;
    status_s[3]         = overflow_r;
    status_s[8 +: CW]   = count_r;
    rd_data_s           = 32'h0;
    if (sel_ram_s) begin
      rd_data_s = mem_r[ram_idx_s];
    end else if (sel_mmio_s) begin
      case (mmio_off_s)
        OFF_LED:      rd_data_s = led_rd_s;
        OFF_STATUS:   rd_data_s = status_s;
        OFF_MTIME_LO: rd_data_s = mtime_r[31:0];
        OFF_MTIME_HI: rd_data_s = mtime_r[63:32];
        default:      rd_data_s = 32'h0;
      endcase
    end else begin
      rd_data_s = 32'h0;
    end
  end

  // Registered read data for the M2 stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= 32'h0;
    end else begin
      rd_data_r <= rd_data_s;
    end
  end

  assign bus.ReadData = rd_data_r;
  assign uart_tx      = uart_tx_r;
  assign led          = led_r;

endmodule
